grid_bank_array: RTL and testbench
==================================

// Module: grid_bank_array
// PURPOSE
// - Banked complex-valued storage for the long-range (PME) charge/potential grid; NY x NZ banks, each DEPTH_X deep, X along address.
// - Generalises the plain read/write grid: adds per-bank accumulate (read-modify-write with hazard forwarding) for charge
//   spreading, a whole-grid clear sweep, and per-bank read-valid tracking. Sits between charge spreader/FFT and grid storage.
// PARAMETERS
// - DATA_REAL_WIDTH   32  real field width (upper half of word)
// - DATA_IMAG_WIDTH   32  imag field width (lower half of word)
// - NY                16  banks in Y
// - NZ                16  banks in Z
// - DEPTH_X           16  words per bank; ADDR_W = $clog2(DEPTH_X)
// PORTS
// - clk          in   1               clock
// - rst          in   1               synchronous, active-high reset
// - clear_start  in   1               pulse: start zeroing every word of every bank
// - clear_busy   out  1               high while clear sweep in progress
// - req_valid    in   [NY][NZ] x 1    per-bank request strobe
// - req_op       in   [NY][NZ] x 2    grid_op_t: OP_READ, OP_WRITE, OP_ACC
// - req_addr     in   [NY][NZ] x ADDR_W  X address
// - req_data     in   [NY][NZ] x W    W = REAL+IMAG; write data or accumulate addend
// - rd_valid     out  [NY][NZ] x 1    read data valid
// - rd_data      out  [NY][NZ] x W    read data
// BEHAVIOUR
// - Reset: clear_busy=0, rd_valid=0, rd_data=0, pipeline valids=0; RAM contents undefined until a clear sweep.
// - Banks fully independent; one request per bank per cycle; no backpressure.
// - OP_READ at cycle t: rd_valid=1, rd_data=mem[addr] at t+2 (RAM read t->t+1, output register t+1->t+2).
// - OP_WRITE at cycle t: mem[addr] written at edge ending t; read of same address issued at t+1 returns new data.
// - OP_ACC at cycle t: RAM read at t; stage-1 at t+1 adds addend; write-back at edge ending t+1. No rd_valid.
//   Real and imag fields added independently, two's complement, modulo width (wrap, no saturation, no carry between fields).
// - Forwarding: stage-1 operand = pending write-back value if stage-1 addr equals addr of the write-back from
//   previous cycle (ACC or WRITE), else RAM output. Back-to-back ACC to same address must accumulate every addend exactly once.
// - READ/WRITE issued at t while ACC to same address is in stage-1: READ returns post-accumulate value; WRITE at t
//   and ACC write-back at t+1 both target addr -> ACC write-back wins (later in program order it is older; forbidden
//   pattern flagged by assertion, not corrected).
// - Clear: clear_start while idle -> clear_busy=1 next cycle; counter 0..DEPTH_X-1 writes 0 to that address in all banks,
//   one address/cycle; clear_busy drops the cycle after address DEPTH_X-1 written (DEPTH_X cycles busy).
//   While busy, req_valid ignored entirely; clear_start while busy ignored. In-flight ACC/READ at clear start complete first
//   (clear counter begins after pipeline drains: latency <= 2 cycles extra).
// - rst mid-clear or mid-accumulate: sweep aborted, pipeline valids dropped, clear_busy=0 next cycle.
// STRUCTURE
// - Package grid_mem_pkg: grid_op_t enum, W/ADDR_W localparams helper, function cplx_add(a,b) (field-wise wrap add).
// - Sub-module grid_bank: one simple-dual-port RAM (registered read) + ACC stage + forwarding compare + output reg.
// - Top: generate NY x NZ grid_bank instances; shared clear FSM (IDLE, DRAIN, SWEEP) and address counter drive all banks.
// TESTING
// - rst; clear_start; wait !clear_busy; READ every addr in bank[0][0], bank[NY-1][NZ-1] -> all rd_data=0, rd_valid at t+2.
// - WRITE bank[3][5] addr 7 = 64'h0000_0010_0000_0020; READ next cycle -> 64'h0000_0010_0000_0020 two cycles later.
// - ACC bank[1][2] addr 4 addend {real=1,imag=-1} on 5 consecutive cycles from zero -> READ gives {5,-5}.
// - ACC real 32'h7FFF_FFFF + 1 -> real 32'h8000_0000, imag field unchanged (no cross-field carry).
// - ACC all banks same cycle, distinct addends; READ all -> each bank holds only its own addend.
// - clear_start during ACC stream; req_valid held high during sweep -> requests ignored, all words 0 after busy drops;
//   rst asserted mid-sweep -> clear_busy=0 next cycle, rd_valid=0.

Source files
------------

// File: rtl/grid_bank_array_pkg.sv
// Shared types, default sizes and the complex-word adder for the banked PME grid storage.
package grid_mem_pkg;

  localparam int DEF_REAL_W  = 32;
  localparam int DEF_IMAG_W  = 32;
  localparam int DEF_NY      = 16;
  localparam int DEF_NZ      = 16;
  localparam int DEF_DEPTH_X = 16;
  localparam int DEF_W       = DEF_REAL_W + DEF_IMAG_W;
  localparam int DEF_ADDR_W  = $clog2(DEF_DEPTH_X);

  // Widest complex word the adder handles; every configured word width must fit.
  localparam int CPLX_MAX_W  = 128;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ACC   = 2'd2
  } grid_op_t;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_DRAIN,
    CLR_SWEEP
  } clr_state_t;

  // Field-wise wrap-around add of two complex words. The imaginary field occupies the
  // low imag_w bits and the real field sits above it. The low sum is masked so its
  // carry never reaches the real field; the caller truncates the result to the word
  // width, which discards the carry out of the real field.
  function automatic logic [CPLX_MAX_W-1:0] cplx_add(
    input logic [CPLX_MAX_W-1:0] a,
    input logic [CPLX_MAX_W-1:0] b,
    input int                    imag_w
  );
    logic [CPLX_MAX_W-1:0] lo_mask;
    logic [CPLX_MAX_W-1:0] lo_sum;
    logic [CPLX_MAX_W-1:0] hi_sum;
    lo_mask = (CPLX_MAX_W'(1) << imag_w) - CPLX_MAX_W'(1);
    lo_sum  = ((a & lo_mask) + (b & lo_mask)) & lo_mask;
    hi_sum  = (a & ~lo_mask) + (b & ~lo_mask);
    return hi_sum | lo_sum;
  endfunction

endpackage

// File: rtl/grid_bank_array_bank.sv
// One grid bank: a register-file RAM with a registered read, a one-stage accumulate
// pipeline with write-back forwarding, and a registered read-data output.
module grid_bank
  import grid_mem_pkg::*;
#(
  parameter int DATA_REAL_WIDTH = DEF_REAL_W,
  parameter int DATA_IMAG_WIDTH = DEF_IMAG_W,
  parameter int DEPTH_X         = DEF_DEPTH_X
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req_valid,
  input  grid_op_t                                 req_op,
  input  logic [$clog2(DEPTH_X)-1:0]               req_addr,
  input  logic [DATA_REAL_WIDTH+DATA_IMAG_WIDTH-1:0] req_data,
  input  logic                                     clr_en,
  input  logic [$clog2(DEPTH_X)-1:0]               clr_addr,
  output logic                                     pending,
  output logic                                     rd_valid,
  output logic [DATA_REAL_WIDTH+DATA_IMAG_WIDTH-1:0] rd_data
);

  localparam int W      = DATA_REAL_WIDTH + DATA_IMAG_WIDTH;
  localparam int ADDR_W = $clog2(DEPTH_X);

  logic [W-1:0]      mem [DEPTH_X];
  logic [W-1:0]      ram_q;

  logic              s1_valid;
  grid_op_t          s1_op;
  logic [ADDR_W-1:0] s1_addr;
  logic [W-1:0]      s1_data;

  logic              lw_valid;
  logic [ADDR_W-1:0] lw_addr;
  logic [W-1:0]      lw_data;

  logic              rd_req;
  logic              wr_req;
  logic              acc_req;
  logic              fwd_hit;
  logic              wb_en;
  logic [W-1:0]      operand;
  logic [W-1:0]      wb_value;

  assign rd_req  = req_valid && (req_op == OP_READ);
  assign wr_req  = req_valid && (req_op == OP_WRITE);
  assign acc_req = req_valid && (req_op == OP_ACC);
  assign pending = s1_valid;

  // Stage-1 operand: the RAM read missed any write made at the edge that captured it,
  // so take the last write-back value when it hit the same address.
  always_comb begin
    fwd_hit  = lw_valid && (lw_addr == s1_addr);
    operand  = fwd_hit ? lw_data : ram_q;
    wb_en    = s1_valid && (s1_op == OP_ACC);
    wb_value = W'(cplx_add(CPLX_MAX_W'(operand), CPLX_MAX_W'(s1_data), DATA_IMAG_WIDTH));
  end

  // RAM read port: registered read for READ and ACC requests.
  always_ff @(posedge clk) begin
    if (rd_req || acc_req) begin
      ram_q <= mem[req_addr];
    end
  end

  // RAM write port: the clear sweep owns the array; otherwise an accumulate write-back
  // lands after a same-cycle WRITE so the older accumulate wins on an address clash.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr_req) begin
        mem[req_addr] <= req_data;
      end
      if (wb_en) begin
        mem[s1_addr] <= wb_value;
      end
    end
  end

  // Stage-1 register: carries READ and ACC requests for one cycle past the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_READ;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_req || acc_req;
      s1_op    <= req_op;
      s1_addr  <= req_addr;
      s1_data  <= req_data;
    end
  end

  // Last-write record feeding the forwarding compare; the accumulate result takes
  // precedence because it is the value that ends up in the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      lw_valid <= 1'b0;
      lw_addr  <= '0;
      lw_data  <= '0;
    end else begin
      lw_valid <= wb_en || wr_req;
      lw_addr  <= wb_en ? s1_addr : req_addr;
      lw_data  <= wb_en ? wb_value : req_data;
    end
  end

  // Read-data output register: presents READ results two cycles after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid && (s1_op == OP_READ);
      if (s1_valid && (s1_op == OP_READ)) begin
        rd_data <= operand;
      end
    end
  end

  // A WRITE colliding with an in-flight accumulate to the same address loses to it;
  // upstream must never issue that pattern.
  write_under_acc : assert property (@(posedge clk) disable iff (rst)
    !(wb_en && wr_req && (req_addr == s1_addr)));

endmodule

// File: rtl/grid_bank_array.sv
// NY x NZ array of independent grid banks sharing one whole-grid clear sequencer.
module grid_bank_array
  import grid_mem_pkg::*;
#(
  parameter int DATA_REAL_WIDTH = DEF_REAL_W,
  parameter int DATA_IMAG_WIDTH = DEF_IMAG_W,
  parameter int NY              = DEF_NY,
  parameter int NZ              = DEF_NZ,
  parameter int DEPTH_X         = DEF_DEPTH_X
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       clear_start,
  output logic                                                       clear_busy,
  input  logic [NY-1:0][NZ-1:0]                                      req_valid,
  input  logic [NY-1:0][NZ-1:0][1:0]                                 req_op,
  input  logic [NY-1:0][NZ-1:0][$clog2(DEPTH_X)-1:0]                 req_addr,
  input  logic [NY-1:0][NZ-1:0][DATA_REAL_WIDTH+DATA_IMAG_WIDTH-1:0] req_data,
  output logic [NY-1:0][NZ-1:0]                                      rd_valid,
  output logic [NY-1:0][NZ-1:0][DATA_REAL_WIDTH+DATA_IMAG_WIDTH-1:0] rd_data
);

  localparam int ADDR_W = $clog2(DEPTH_X);

  clr_state_t        state;
  clr_state_t        next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] next_cnt;
  logic              clr_en;
  logic              any_pending;
  logic [NY-1:0][NZ-1:0] pending;

  assign clear_busy  = (state != CLR_IDLE);
  assign any_pending = |pending;

  // Clear sequencer state and sweep address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLR_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  // Clear sequencing: wait for in-flight accumulates to retire, then zero one address
  // per cycle across every bank.
  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    clr_en     = 1'b0;
    case (state)
      CLR_IDLE: begin
        next_cnt = '0;
        if (clear_start) begin
          next_state = CLR_DRAIN;
        end
      end
      CLR_DRAIN: begin
        if (!any_pending) begin
          next_state = CLR_SWEEP;
        end
      end
      CLR_SWEEP: begin
        clr_en = 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH_X - 1)) begin
          next_state = CLR_IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = clr_cnt + 1'b1;
        end
      end
      default: begin
        next_state = CLR_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  for (genvar y = 0; y < NY; y++) begin : g_y
    for (genvar z = 0; z < NZ; z++) begin : g_z
      grid_bank #(
        .DATA_REAL_WIDTH (DATA_REAL_WIDTH),
        .DATA_IMAG_WIDTH (DATA_IMAG_WIDTH),
        .DEPTH_X         (DEPTH_X)
      ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[y][z] && !clear_busy),
        .req_op    (grid_op_t'(req_op[y][z])),
        .req_addr  (req_addr[y][z]),
        .req_data  (req_data[y][z]),
        .clr_en    (clr_en),
        .clr_addr  (clr_cnt),
        .pending   (pending[y][z]),
        .rd_valid  (rd_valid[y][z]),
        .rd_data   (rd_data[y][z])
      );
    end
  end

endmodule

// File: tb/tb_grid_bank_array.sv
// Randomised scoreboard bench for grid_bank_array with a program-order memory model.
module tb_grid_bank_array;
  import grid_mem_pkg::*;

  localparam int NY    = DEF_NY;
  localparam int NZ    = DEF_NZ;
  localparam int DEPTH = DEF_DEPTH_X;
  localparam int W     = DEF_W;
  localparam int AW    = DEF_ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic clear_start;
  logic clear_busy;
  logic [NY-1:0][NZ-1:0]         req_valid;
  logic [NY-1:0][NZ-1:0][1:0]    req_op;
  logic [NY-1:0][NZ-1:0][AW-1:0] req_addr;
  logic [NY-1:0][NZ-1:0][W-1:0]  req_data;
  logic [NY-1:0][NZ-1:0]         rd_valid;
  logic [NY-1:0][NZ-1:0][W-1:0]  rd_data;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q [NY][NZ][$];
  logic [W-1:0] model [NY][NZ][DEPTH];
  logic         acc_prev_v [NY][NZ];
  logic [AW-1:0] acc_prev_a [NY][NZ];
  logic         acc_cur_v [NY][NZ];
  logic [AW-1:0] acc_cur_a [NY][NZ];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  bit           ignore_reqs = 1'b0;

  grid_bank_array #(
    .DATA_REAL_WIDTH (DEF_REAL_W),
    .DATA_IMAG_WIDTH (DEF_IMAG_W),
    .NY              (NY),
    .NZ              (NZ),
    .DEPTH_X         (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Complex add as the arithmetic rule states it: each 32-bit field wraps on its own.
  function automatic logic [W-1:0] cadd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] re;
    logic [31:0] im;
    re = a[63:32] + b[63:32];
    im = a[31:0] + b[31:0];
    return {re, im};
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drive one bank request for the current cycle and advance the model in program order.
  task automatic applyStimulus(input int y, input int z, input logic [1:0] op,
                               input logic [AW-1:0] addr, input logic [W-1:0] data);
    exp_t e;
    req_valid[y][z] = 1'b1;
    req_op[y][z]    = op;
    req_addr[y][z]  = addr;
    req_data[y][z]  = data;
    if (!ignore_reqs) begin
      if (op == OP_READ) begin
        e.data = model[y][z][addr];
        e.due  = cyc + 2;
        exp_q[y][z].push_back(e);
      end else if (op == OP_WRITE) begin
        model[y][z][addr] = data;
      end else if (op == OP_ACC) begin
        model[y][z][addr] = cadd(model[y][z][addr], data);
        acc_cur_v[y][z] = 1'b1;
        acc_cur_a[y][z] = addr;
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    req_valid   = '0;
    clear_start = 1'b0;
    for (int y = 0; y < NY; y++) begin
      for (int z = 0; z < NZ; z++) begin
        acc_prev_v[y][z] = acc_cur_v[y][z];
        acc_prev_a[y][z] = acc_cur_a[y][z];
        acc_cur_v[y][z]  = 1'b0;
      end
    end
  endtask

  task automatic driveGarbage();
    for (int y = 0; y < NY; y++) begin
      for (int z = 0; z < NZ; z++) begin
        req_valid[y][z] = 1'b1;
        req_op[y][z]    = 2'($urandom_range(0, 2));
        req_addr[y][z]  = AW'($urandom_range(0, DEPTH - 1));
        req_data[y][z]  = {$urandom, $urandom};
      end
    end
  endtask

  // Pulse clear_start in the current cycle, optionally flood every bank with requests
  // while the sweep runs, and wait (bounded) for the sweep to finish.
  task automatic doClear(input bit garbage);
    int busy_cnt;
    clear_start = 1'b1;
    for (int y = 0; y < NY; y++)
      for (int z = 0; z < NZ; z++)
        for (int a = 0; a < DEPTH; a++)
          model[y][z][a] = '0;
    nextCycle();
    checkOutput("busy_rise", W'(clear_busy), W'(1));
    ignore_reqs = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      if (clear_busy !== 1'b1) break;
      busy_cnt++;
      if (garbage && i < DEPTH) driveGarbage();
      nextCycle();
    end
    ignore_reqs = 1'b0;
    checkOutput("busy_fall", W'(clear_busy), W'(0));
    total++;
    if (busy_cnt < DEPTH || busy_cnt > DEPTH + 2) begin
      bad++;
      $display("[TB] FAIL busy_len actual=%0d required=%0d..%0d", busy_cnt, DEPTH, DEPTH + 2);
    end
  endtask

  task automatic readBank(input int y, input int z);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(y, z, OP_READ, AW'(a), '0);
      nextCycle();
    end
  endtask

  // Scoreboard monitor: every presented read must match the oldest expected entry on time.
  always @(negedge clk) begin
    for (int y = 0; y < NY; y++) begin
      for (int z = 0; z < NZ; z++) begin
        exp_t e;
        while (exp_q[y][z].size() > 0 && exp_q[y][z][0].due < cyc) begin
          e = exp_q[y][z].pop_front();
          total++;
          bad++;
          $display("[TB] FAIL missing_rd bank[%0d][%0d] actual=none required=%h", y, z, e.data);
        end
        if (rd_valid[y][z] === 1'b1) begin
          if (exp_q[y][z].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_rd bank[%0d][%0d] actual=%h required=none", y, z, rd_data[y][z]);
          end else begin
            e = exp_q[y][z].pop_front();
            checkOutput($sformatf("rd_data[%0d][%0d]", y, z), rd_data[y][z], e.data);
            checkOutput($sformatf("rd_cycle[%0d][%0d]", y, z), W'(cyc), W'(e.due));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nonempty;
    rst = 1'b1;
    clear_start = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_addr = '0;
    req_data = '0;
    for (int y = 0; y < NY; y++)
      for (int z = 0; z < NZ; z++) begin
        acc_prev_v[y][z] = 1'b0;
        acc_cur_v[y][z]  = 1'b0;
        acc_prev_a[y][z] = '0;
        acc_cur_a[y][z]  = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_clear_busy", W'(clear_busy), W'(0));
    checkOutput("rst_rd_valid_any", W'(|rd_valid), W'(0));
    checkOutput("rst_rd_data_any", W'(|rd_data), W'(0));
    rst = 1'b0;
    nextCycle();

    // Cleared grid reads back zero in the corner banks.
    doClear(1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(0, 0, OP_READ, AW'(a), '0);
      applyStimulus(NY - 1, NZ - 1, OP_READ, AW'(a), '0);
      nextCycle();
    end

    // Write then read on the next cycle.
    applyStimulus(3, 5, OP_WRITE, 4'd7, 64'h0000_0010_0000_0020);
    nextCycle();
    applyStimulus(3, 5, OP_READ, 4'd7, '0);
    nextCycle();

    // Five back-to-back accumulates of {1,-1}.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2, OP_ACC, 4'd4, 64'h0000_0001_FFFF_FFFF);
      nextCycle();
    end
    applyStimulus(1, 2, OP_READ, 4'd4, '0);
    nextCycle();

    // Field overflow in either half must not spill into the other.
    applyStimulus(2, 2, OP_WRITE, 4'd1, 64'h7FFF_FFFF_1234_5678);
    nextCycle();
    applyStimulus(2, 2, OP_WRITE, 4'd2, 64'h0000_0005_FFFF_FFFF);
    nextCycle();
    applyStimulus(2, 2, OP_ACC, 4'd1, 64'h0000_0001_0000_0000);
    nextCycle();
    applyStimulus(2, 2, OP_ACC, 4'd2, 64'h0000_0000_0000_0001);
    nextCycle();
    applyStimulus(2, 2, OP_READ, 4'd1, '0);
    nextCycle();
    applyStimulus(2, 2, OP_READ, 4'd2, '0);
    nextCycle();

    // Every bank accumulates its own addend in the same cycle, then reads it back.
    for (int y = 0; y < NY; y++)
      for (int z = 0; z < NZ; z++)
        applyStimulus(y, z, OP_ACC, 4'd9, {32'(y * NZ + z + 1), 32'(-(y * NZ + z + 1))});
    nextCycle();
    for (int y = 0; y < NY; y++)
      for (int z = 0; z < NZ; z++)
        applyStimulus(y, z, OP_READ, 4'd9, '0);
    nextCycle();

    // Random traffic concentrated on a few addresses to exercise forwarding.
    for (int c = 0; c < 300; c++) begin
      for (int y = 0; y < NY; y++) begin
        for (int z = 0; z < NZ; z++) begin
          if ($urandom_range(0, 1) == 1) begin
            logic [1:0]    op;
            logic [AW-1:0] addr;
            op   = 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                               : AW'($urandom_range(0, 3));
            if (op == OP_WRITE && acc_prev_v[y][z] && acc_prev_a[y][z] == addr) op = OP_READ;
            applyStimulus(y, z, op, addr, {$urandom, $urandom});
          end
        end
      end
      nextCycle();
    end
    repeat (3) nextCycle();

    // Clear launched under an accumulate stream with requests held during the sweep.
    for (int c = 0; c < 4; c++) begin
      for (int y = 0; y < 4; y++)
        for (int z = 0; z < 4; z++)
          applyStimulus(y, z, OP_ACC, AW'(c), {$urandom, $urandom});
      applyStimulus(5, 5, OP_READ, AW'(c), '0);
      if (c < 3) nextCycle();
    end
    doClear(1'b1);
    readBank(1, 2);
    readBank(3, 5);
    readBank(NY - 1, 0);
    repeat (3) nextCycle();

    // Reset in the middle of a sweep aborts it at the next edge.
    clear_start = 1'b1;
    nextCycle();
    repeat (5) nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("rst_mid_clear_busy", W'(clear_busy), W'(0));
    checkOutput("rst_mid_rd_valid_any", W'(|rd_valid), W'(0));
    rst = 1'b0;
    nextCycle();
    doClear(1'b0);
    applyStimulus(3, 5, OP_READ, 4'd7, '0);
    nextCycle();
    applyStimulus(0, 1, OP_WRITE, 4'd3, 64'hDEAD_BEEF_0BAD_F00D);
    nextCycle();
    applyStimulus(0, 1, OP_READ, 4'd3, '0);
    repeat (4) nextCycle();

    nonempty = 0;
    for (int y = 0; y < NY; y++)
      for (int z = 0; z < NZ; z++)
        nonempty += exp_q[y][z].size();
    checkOutput("sb_leftover", W'(nonempty), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
